// File: rtl/relop_pkg.sv
// Shared constants and types for the relational-operator response checker.
package relop_pkg;
    localparam int RES_W = 8;

    // Bit positions inside the 8-bit result vector, MSB first.
    localparam int EQ_B   = 7;
    localparam int NEQ_B  = 6;
    localparam int CEQ_B  = 5;
    localparam int CNEQ_B = 4;
    localparam int LT_B   = 3;
    localparam int GT_B   = 2;
    localparam int LTE_B  = 1;
    localparam int GTE_B  = 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/relop_ref.sv
// Combinational 2-state reference model: operand pair -> expected result vector.
module relop_ref
    import relop_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [RES_W-1:0] exp_res
);
    logic eq;
    logic lt;
    logic gt;

    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
        exp_res         = '0;
        exp_res[EQ_B]   = eq;
        exp_res[NEQ_B]  = ~eq;
        exp_res[CEQ_B]  = eq;
        exp_res[CNEQ_B] = ~eq;
        exp_res[LT_B]   = lt;
        exp_res[GT_B]   = gt;
        exp_res[LTE_B]  = ~gt;
        exp_res[GTE_B]  = ~lt;
    end
endmodule

// File: rtl/relop_checker.sv
// Response checker: accepts vectors, compares against relop_ref one cycle later,
// keeps saturating pass/fail counts and captures the first mismatch.
module relop_checker
    import relop_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [RES_W-1:0] dut_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [RES_W-1:0] first_fail_exp,
    output logic [RES_W-1:0] first_fail_got
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] accepted_idx;
    logic             hs;

    // S1 holds the accepted vector; the compare (S2) retires it on the next edge.
    logic             s1_vld;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [RES_W-1:0] s1_res;
    logic [CNT_W-1:0] s1_idx;
    logic [RES_W-1:0] exp_res;
    logic             mismatch;

    relop_ref #(.WIDTH(WIDTH)) u_ref (
        .a       (s1_a),
        .b       (s1_b),
        .exp_res (exp_res)
    );

    assign in_ready = (state == RUN) && (remaining != '0);
    assign hs       = in_valid && in_ready;
    assign mismatch = (exp_res != s1_res);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
            RUN:     if (hs && remaining == CNT_ONE) state_nxt = DRAIN;
            DRAIN:   if (!s1_vld) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            remaining      <= '0;
            accepted_idx   <= '0;
            s1_vld         <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_res         <= '0;
            s1_idx         <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else begin
            state  <= state_nxt;
            s1_vld <= hs;
            if (hs) begin
                s1_a         <= a;
                s1_b         <= b;
                s1_res       <= dut_res;
                s1_idx       <= accepted_idx;
                remaining    <= remaining - CNT_ONE;
                accepted_idx <= accepted_idx + CNT_ONE;
            end
            if (state == IDLE && start) begin
                remaining      <= num_vec;
                accepted_idx   <= '0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                err            <= 1'b0;
                first_fail_idx <= '0;
                first_fail_exp <= '0;
                first_fail_got <= '0;
            end else if (s1_vld) begin
                if (mismatch) begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                    err <= 1'b1;
                    if (!err) begin
                        first_fail_idx <= s1_idx;
                        first_fail_exp <= exp_res;
                        first_fail_got <= s1_res;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_relop_checker.sv
// Directed + randomized bench for relop_checker with a scoreboard-style model.
module tb_relop_checker;
    localparam int W   = 4;
    localparam int CW  = 16;
    localparam int CW2 = 2;

    logic           clk = 1'b0;
    logic           rst_n, start, start2, in_valid;
    logic [CW-1:0]  num_vec;
    logic [CW2-1:0] num_vec2;
    logic [W-1:0]   a, b;
    logic [7:0]     dut_res;

    logic           in_ready, busy, done, err;
    logic [CW-1:0]  pass_cnt, fail_cnt, ffi;
    logic [7:0]     ffe, ffg;
    logic           in_ready2, busy2, done2, err2;
    logic [CW2-1:0] pass_cnt2, fail_cnt2, ffi2;
    logic [7:0]     ffe2, ffg2;

    relop_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .dut_res(dut_res),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
        .first_fail_idx(ffi), .first_fail_exp(ffe), .first_fail_got(ffg)
    );

    // Narrow-counter instance used for the saturation case.
    relop_checker #(.WIDTH(W), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num_vec2),
        .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .dut_res(dut_res),
        .busy(busy2), .done(done2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err(err2),
        .first_fail_idx(ffi2), .first_fail_exp(ffe2), .first_fail_got(ffg2)
    );

    always #5 clk = ~clk;

    int         ncmp = 0;
    int         nerr = 0;
    int         m_pass, m_fail, m_idx, m_ffi;
    logic       m_err;
    logic [7:0] m_ffe, m_ffg;
    bit         sel2;

    function automatic logic [7:0] ref_vec(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [7:0] r;
        r = {x == y, x != y, x == y, x != y, x < y, x > y, x <= y, x >= y};
        return r;
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [7:0] rr);
        logic       rdy;
        logic [7:0] e;
        in_valid = v; a = aa; b = bb; dut_res = rr;
        rdy = sel2 ? in_ready2 : in_ready;
        if (v && rdy) begin
            e = ref_vec(aa, bb);
            if (e === rr) m_pass++;
            else begin
                if (!m_err) begin m_ffi = m_idx; m_ffe = e; m_ffg = rr; end
                m_err = 1'b1;
                m_fail++;
            end
            m_idx++;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic begin_run(input int n);
        m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 0; m_err = 1'b0; m_ffe = '0; m_ffg = '0;
        if (sel2) begin start2 = 1'b1; num_vec2 = CW2'(n); end
        else      begin start  = 1'b1; num_vec  = CW'(n);  end
        step();
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic check_results(input string tag);
        int lim;
        lim = sel2 ? 3 : 65535;
        chk({tag, ".pass"}, sel2 ? 32'(pass_cnt2) : 32'(pass_cnt), 32'(imin(m_pass, lim)));
        chk({tag, ".fail"}, sel2 ? 32'(fail_cnt2) : 32'(fail_cnt), 32'(imin(m_fail, lim)));
        chk({tag, ".err"},  sel2 ? 32'(err2) : 32'(err), 32'(m_err));
        chk({tag, ".ffi"},  sel2 ? 32'(ffi2) : 32'(ffi), 32'(m_ffi));
        chk({tag, ".ffe"},  sel2 ? 32'(ffe2) : 32'(ffe), 32'(m_ffe));
        chk({tag, ".ffg"},  sel2 ? 32'(ffg2) : 32'(ffg), 32'(m_ffg));
    endtask

    // Called right after the edge that took the final handshake.
    task automatic finish_run(input string tag);
        chk({tag, ".drain_busy"},  32'(busy), 32'(1));
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'(0));
        chk({tag, ".drain_done"},  32'(done), 32'(0));
        step();
        chk({tag, ".drain2_done"}, 32'(done), 32'(0));
        check_results({tag, ".final"});
        step();
        chk({tag, ".done"},      32'(done), 32'(1));
        chk({tag, ".done_busy"}, 32'(busy), 32'(1));
        step();
        chk({tag, ".idle_done"}, 32'(done), 32'(0));
        chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
        check_results({tag, ".hold"});
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".ready"}, 32'(in_ready), 32'(0));
        chk({tag, ".busy"},  32'(busy), 32'(0));
        chk({tag, ".done"},  32'(done), 32'(0));
        chk({tag, ".pass"},  32'(pass_cnt), 32'(0));
        chk({tag, ".fail"},  32'(fail_cnt), 32'(0));
        chk({tag, ".err"},   32'(err), 32'(0));
        chk({tag, ".ffi"},   32'(ffi), 32'(0));
        chk({tag, ".ffe"},   32'(ffe), 32'(0));
        chk({tag, ".ffg"},   32'(ffg), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        logic [W-1:0] ra, rb;
        logic [7:0]   rr;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b1;
        num_vec = '0; num_vec2 = '0; a = '0; b = '0; dut_res = '0; sel2 = 1'b0;
        repeat (2) step();
        chk_cleared("reset");
        chk("reset.ready2", 32'(in_ready2), 32'(0));
        chk("reset.fail2",  32'(fail_cnt2), 32'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        step();

        // All-matching run, back-to-back
        begin_run(3);
        chk("match.ready", 32'(in_ready), 32'(1));
        drive(1'b1, 4'b1101, 4'b0101, 8'h55);
        drive(1'b1, 4'b0011, 4'b0011, 8'hA3);
        drive(1'b1, 4'b0011, 4'b0101, 8'h5A);
        finish_run("match");
        chk("match.pass_const", 32'(pass_cnt), 32'(3));
        chk("match.fail_const", 32'(fail_cnt), 32'(0));

        // First-mismatch capture
        begin_run(2);
        drive(1'b1, 4'b0011, 4'b0011, 8'hA2);
        drive(1'b1, 4'b1101, 4'b0101, 8'h00);
        finish_run("mism");
        chk("mism.fail_const", 32'(fail_cnt), 32'(2));
        chk("mism.ffi_const",  32'(ffi), 32'(0));
        chk("mism.ffe_const",  32'(ffe), 32'hA3);
        chk("mism.ffg_const",  32'(ffg), 32'hA2);

        // Bubbles
        begin_run(2);
        drive(1'b1, 4'b1101, 4'b0101, 8'h55);
        drive(1'b0, 4'b0000, 4'b0001, 8'hFF);
        drive(1'b0, 4'b0000, 4'b0001, 8'hFF);
        drive(1'b1, 4'b0011, 4'b0011, 8'hA3);
        finish_run("bubble");
        chk("bubble.pass_const", 32'(pass_cnt), 32'(2));

        // Zero-length run
        start = 1'b1; num_vec = '0;
        step();
        start = 1'b0;
        chk("zero.done", 32'(done), 32'(1));
        chk("zero.busy", 32'(busy), 32'(1));
        chk("zero.pass", 32'(pass_cnt), 32'(0));
        chk("zero.fail", 32'(fail_cnt), 32'(0));
        step();
        chk("zero.done_after", 32'(done), 32'(0));
        chk("zero.busy_after", 32'(busy), 32'(0));

        // start during RUN must be ignored
        begin_run(3);
        drive(1'b1, 4'b0001, 4'b0010, ref_vec(4'b0001, 4'b0010));
        start = 1'b1; num_vec = CW'(7);
        drive(1'b1, 4'b1111, 4'b0000, ref_vec(4'b1111, 4'b0000));
        start = 1'b0;
        drive(1'b1, 4'b0110, 4'b0110, ref_vec(4'b0110, 4'b0110));
        finish_run("restart");

        // Randomized runs with bubbles and corrupted results
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 10);
            begin_run(n);
            cyc = 0;
            while (m_idx < n && cyc < 200) begin
                ra = W'($urandom_range(0, 15));
                rb = W'($urandom_range(0, 15));
                rr = ref_vec(ra, rb);
                if ($urandom_range(0, 3) == 0) rr = rr ^ 8'($urandom_range(1, 255));
                drive($urandom_range(0, 3) != 0, ra, rb, rr);
                cyc++;
            end
            chk("rand.handshakes", 32'(m_idx), 32'(n));
            finish_run("rand");
        end

        // Saturation on the narrow instance: 5 failing vectors offered, 3 accepted
        sel2 = 1'b1;
        begin_run(3);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b0011, 4'b0011, 8'h00);
        chk("sat.done",  32'(done2), 32'(1));
        chk("sat.fail_const", 32'(fail_cnt2), 32'(3));
        check_results("sat");
        step();
        chk("sat.done_after", 32'(done2), 32'(0));
        sel2 = 1'b0;

        // Reset mid-run aborts without done
        begin_run(5);
        drive(1'b1, 4'b0011, 4'b0011, 8'h00);
        drive(1'b1, 4'b0101, 4'b0011, 8'h55);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_cleared("abort");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort.no_done", 32'(done), 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
